crtc_param: RTL and testbench

Parametrised CRT/VGA timing controller, the successor to the fixed 640x480 `CRCT`. It generates the pixel strobe, sync, blanking, active, end-of-frame and end-of-screen pulses, and a scaled framebuffer address from one system clock. Timings, sync polarity, clock divide ratio and framebuffer down-scaling are all parameters. It sits between the system clock and the framebuffer read port / DAC output stage of the VGA pipeline.

---
 rtl/crtc_param.sv | 160 ++++++++++++++++
 tb/tb_crtc_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_param.sv
`default_nettype none
// ============================================================================
// Module   : crtc_param
// Purpose  : Parametrised CRT/VGA timing controller. Produces the pixel
//            strobe, sync, blanking/active, end-of-frame and end-of-screen
//            pulses and a down-scaled framebuffer address from one clock.
// Ports    : i_clk, i_rst (sync, active-high), i_en (run enable)
//            o_pix_stb, o_hs, o_vs, o_blanking, o_active, o_frameend,
//            o_screenend, o_x, o_y, o_xy, o_h_count, o_v_count, o_frame_cnt
// Revision : 1.0 - initial release
// ============================================================================
module crtc_param #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int PIX_DIV     = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int CW          = 10,
    parameter int AW          = 17
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic          o_pix_stb,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_blanking,
    output logic          o_active,
    output logic          o_frameend,
    output logic          o_screenend,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic [AW-1:0] o_xy,
    output logic [CW-1:0] o_h_count,
    output logic [CW-1:0] o_v_count,
    output logic [7:0]    o_frame_cnt
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_dw      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [c_dw-1:0] c_div_last = c_dw'(PIX_DIV - 1);
    localparam logic [CW-1:0]   c_h_last   = CW'(c_h_total - 1);
    localparam logic [CW-1:0]   c_v_last   = CW'(c_v_total - 1);
    localparam logic [CW-1:0]   c_h_act    = CW'(H_ACTIVE);
    localparam logic [CW-1:0]   c_v_act    = CW'(V_ACTIVE);
    localparam logic [CW-1:0]   c_h_act_m1 = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0]   c_v_act_m1 = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0]   c_hs_first = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]   c_hs_last  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0]   c_vs_first = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]   c_vs_last  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0]   c_v_mask   = CW'((1 << SCALE_SHIFT) - 1);
    localparam logic [AW-1:0]   c_row_step = AW'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic            c_hs_pol   = (HS_POL != 0);
    localparam logic            c_vs_pol   = (VS_POL != 0);

    // Elaboration-time sanity checks on the parameter set
    if (c_h_total - 1 >= (1 << CW)) begin : g_chk_h_width
        $error("crtc_param: H_TOTAL-1 does not fit in CW bits");
    end
    if (c_v_total - 1 >= (1 << CW)) begin : g_chk_v_width
        $error("crtc_param: V_TOTAL-1 does not fit in CW bits");
    end
    if ((V_ACTIVE >> SCALE_SHIFT) * (H_ACTIVE >> SCALE_SHIFT) - 1 >= (1 << AW)) begin : g_chk_aw
        $error("crtc_param: framebuffer size does not fit in AW bits");
    end
    if (((H_ACTIVE % (1 << SCALE_SHIFT)) != 0) || ((V_ACTIVE % (1 << SCALE_SHIFT)) != 0)) begin : g_chk_scale
        $error("crtc_param: active size not divisible by 2^SCALE_SHIFT");
    end
    if (PIX_DIV < 1) begin : g_chk_div
        $error("crtc_param: PIX_DIV must be at least 1");
    end

    logic [c_dw-1:0] r_div_q, w_div_d;
    logic [CW-1:0]   r_h_q, w_h_d;
    logic [CW-1:0]   r_v_q, w_v_d;
    logic [AW-1:0]   r_row_q, w_row_d;
    logic [7:0]      r_fc_q, w_fc_d;

    logic w_stb, w_h_end, w_v_end, w_active, w_hs_on, w_vs_on, w_screenend;

    // With PIX_DIV=1 the divider is stuck at 0 == c_div_last, so the strobe follows i_en.
    assign w_stb       = i_en && (r_div_q == c_div_last);
    assign w_h_end     = (r_h_q == c_h_last);
    assign w_v_end     = (r_v_q == c_v_last);
    assign w_active    = (r_h_q < c_h_act) && (r_v_q < c_v_act);
    assign w_hs_on     = (r_h_q >= c_hs_first) && (r_h_q <= c_hs_last);
    assign w_vs_on     = (r_v_q >= c_vs_first) && (r_v_q <= c_vs_last);
    assign w_screenend = w_stb && w_h_end && w_v_end;

    always_comb begin
        w_div_d = r_div_q;
        w_h_d   = r_h_q;
        w_v_d   = r_v_q;
        w_row_d = r_row_q;
        w_fc_d  = r_fc_q;
        if (i_en) begin
            w_div_d = w_stb ? '0 : r_div_q + 1'b1;
        end
        if (w_stb) begin
            if (w_h_end) begin
                w_h_d = '0;
                w_v_d = w_v_end ? '0 : r_v_q + 1'b1;
                // row_base tracks (v>>S)*(H_ACTIVE>>S): step once per block of
                // 2^S active lines, i.e. when leaving the last line of a block.
                if (w_v_end) begin
                    w_row_d = '0;
                end else if ((r_v_q < c_v_act) && ((r_v_q & c_v_mask) == c_v_mask)) begin
                    w_row_d = r_row_q + c_row_step;
                end
            end else begin
                w_h_d = r_h_q + 1'b1;
            end
        end
        if (w_screenend) begin
            w_fc_d = r_fc_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_q <= '0;
            r_h_q   <= '0;
            r_v_q   <= '0;
            r_row_q <= '0;
            r_fc_q  <= '0;
        end else begin
            r_div_q <= w_div_d;
            r_h_q   <= w_h_d;
            r_v_q   <= w_v_d;
            r_row_q <= w_row_d;
            r_fc_q  <= w_fc_d;
        end
    end

    assign o_pix_stb   = w_stb;
    assign o_hs        = c_hs_pol ? w_hs_on : !w_hs_on;
    assign o_vs        = c_vs_pol ? w_vs_on : !w_vs_on;
    assign o_active    = w_active;
    assign o_blanking  = !w_active;
    assign o_frameend  = w_stb && (r_h_q == c_h_act_m1) && (r_v_q == c_v_act_m1);
    assign o_screenend = w_screenend;
    assign o_x         = w_active ? r_h_q : '0;
    assign o_y         = w_active ? r_v_q : '0;
    assign o_xy        = w_active ? (r_row_q + AW'(r_h_q >> SCALE_SHIFT)) : '0;
    assign o_h_count   = r_h_q;
    assign o_v_count   = r_v_q;
    assign o_frame_cnt = r_fc_q;

endmodule
`default_nettype wire

// File: tb/tb_crtc_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_crtc_param
// Purpose  : Self-checking bench for crtc_param. Two instances share the
//            stimulus: a small active-low configuration with PIX_DIV=2 and
//            an active-high configuration with PIX_DIV=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crtc_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;

    typedef struct packed {
        logic        stb, hs, vs, blank, act, fe, se;
        logic [9:0]  x, y;
        logic [16:0] xy;
        logic [9:0]  hc, vc;
        logic [7:0]  fc;
    } exp_t;

    typedef struct {
        int          h, v;
        logic [16:0] xy;
        logic        act, hs, vs, fe, se;
    } vec_t;

    logic        d0_stb, d0_hs, d0_vs, d0_blank, d0_act, d0_fe, d0_se;
    logic [9:0]  d0_x, d0_y, d0_hc, d0_vc;
    logic [16:0] d0_xy;
    logic [7:0]  d0_fc;
    logic        d1_stb, d1_hs, d1_vs, d1_blank, d1_act, d1_fe, d1_se;
    logic [9:0]  d1_x, d1_y, d1_hc, d1_vc;
    logic [16:0] d1_xy;
    logic [7:0]  d1_fc;

    crtc_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .PIX_DIV(2), .SCALE_SHIFT(1), .CW(10), .AW(17)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_pix_stb(d0_stb), .o_hs(d0_hs), .o_vs(d0_vs), .o_blanking(d0_blank),
        .o_active(d0_act), .o_frameend(d0_fe), .o_screenend(d0_se),
        .o_x(d0_x), .o_y(d0_y), .o_xy(d0_xy),
        .o_h_count(d0_hc), .o_v_count(d0_vc), .o_frame_cnt(d0_fc)
    );

    crtc_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIX_DIV(1), .SCALE_SHIFT(1), .CW(10), .AW(17)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_pix_stb(d1_stb), .o_hs(d1_hs), .o_vs(d1_vs), .o_blanking(d1_blank),
        .o_active(d1_act), .o_frameend(d1_fe), .o_screenend(d1_se),
        .o_x(d1_x), .o_y(d1_y), .o_xy(d1_xy),
        .o_h_count(d1_hc), .o_v_count(d1_vc), .o_frame_cnt(d1_fc)
    );

    exp_t got0, got1;
    assign got0 = {d0_stb, d0_hs, d0_vs, d0_blank, d0_act, d0_fe, d0_se,
                   d0_x, d0_y, d0_xy, d0_hc, d0_vc, d0_fc};
    assign got1 = {d1_stb, d1_hs, d1_vs, d1_blank, d1_act, d1_fe, d1_se,
                   d1_x, d1_y, d1_xy, d1_hc, d1_vc, d1_fc};

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   phase1 = 1'b0;
    exp_t sb_q[$];

    // Reference model state, index 0 = PIX_DIV 2 / active-low, 1 = PIX_DIV 1 / active-high
    int m_div[2], m_h[2], m_v[2], m_fc[2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic exp_t model_out(input int id, input logic e);
        exp_t r;
        int   pd;
        bit   hs_on, vs_on;
        pd      = (id == 0) ? 2 : 1;
        r.stb   = e && (m_div[id] == pd - 1);
        r.act   = (m_h[id] < 8) && (m_v[id] < 4);
        r.blank = !r.act;
        hs_on   = (m_h[id] >= 10) && (m_h[id] <= 12);
        vs_on   = (m_v[id] >= 5) && (m_v[id] <= 6);
        r.hs    = (id == 1) ? hs_on : !hs_on;
        r.vs    = (id == 1) ? vs_on : !vs_on;
        r.fe    = r.stb && (m_h[id] == 7) && (m_v[id] == 3);
        r.se    = r.stb && (m_h[id] == 13) && (m_v[id] == 7);
        r.x     = r.act ? 10'(m_h[id]) : 10'd0;
        r.y     = r.act ? 10'(m_v[id]) : 10'd0;
        r.xy    = r.act ? 17'((m_v[id] / 2) * 4 + m_h[id] / 2) : 17'd0;
        r.hc    = 10'(m_h[id]);
        r.vc    = 10'(m_v[id]);
        r.fc    = 8'(m_fc[id]);
        return r;
    endfunction

    function automatic void model_adv(input int id, input logic r, input logic e);
        int pd;
        pd = (id == 0) ? 2 : 1;
        if (r) begin
            m_div[id] = 0; m_h[id] = 0; m_v[id] = 0; m_fc[id] = 0;
        end else if (e) begin
            if (m_div[id] == pd - 1) begin
                m_div[id] = 0;
                if (m_h[id] == 13) begin
                    m_h[id] = 0;
                    if (m_v[id] == 7) begin
                        m_v[id]  = 0;
                        m_fc[id] = (m_fc[id] + 1) % 256;
                    end else begin
                        m_v[id]++;
                    end
                end else begin
                    m_h[id]++;
                end
            end else begin
                m_div[id]++;
            end
        end
    endfunction

    // One clock: drive at the falling edge, check 1 ns later, advance model at the rising edge.
    task automatic step(input logic r, input logic e);
        exp_t ex;
        rst = r;
        en  = e;
        #1;
        sb_q.push_back(model_out(0, e));
        sb_q.push_back(model_out(1, e));
        ex = sb_q.pop_front();
        total++;
        if (got0 !== ex) begin
            bad++;
            $display("FAIL sb_dut0 cyc=%0d: got=%h expected=%h", cyc, got0, ex);
        end
        ex = sb_q.pop_front();
        total++;
        if (got1 !== ex) begin
            bad++;
            $display("FAIL sb_dut1 cyc=%0d: got=%h expected=%h", cyc, got1, ex);
        end
        if (phase1 && cyc == 111) chk("dut1_screenend_111", 64'(d1_se), 64'd1);
        if (phase1 && cyc == 112) chk("dut1_frame_cnt_112", 64'(d1_fc), 64'd1);
        @(posedge clk);
        model_adv(0, r, e);
        model_adv(1, r, e);
        if (r) cyc = 0;
        else   cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 5000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        rst = 1'b0;
        en  = 1'b1;
        #1;
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{h:0,  v:0, xy:17'd0, act:1'b1, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[1]  = '{h:7,  v:0, xy:17'd3, act:1'b1, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[2]  = '{h:8,  v:0, xy:17'd0, act:1'b0, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[3]  = '{h:10, v:0, xy:17'd0, act:1'b0, hs:1'b0, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[4]  = '{h:12, v:0, xy:17'd0, act:1'b0, hs:1'b0, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[5]  = '{h:13, v:0, xy:17'd0, act:1'b0, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[6]  = '{h:1,  v:1, xy:17'd0, act:1'b1, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[7]  = '{h:0,  v:2, xy:17'd4, act:1'b1, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[8]  = '{h:7,  v:3, xy:17'd7, act:1'b1, hs:1'b1, vs:1'b1, fe:1'b1, se:1'b0};
        tbl[9]  = '{h:0,  v:4, xy:17'd0, act:1'b0, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b0};
        tbl[10] = '{h:0,  v:5, xy:17'd0, act:1'b0, hs:1'b1, vs:1'b0, fe:1'b0, se:1'b0};
        tbl[11] = '{h:11, v:6, xy:17'd0, act:1'b0, hs:1'b0, vs:1'b0, fe:1'b0, se:1'b0};
        tbl[12] = '{h:13, v:7, xy:17'd0, act:1'b0, hs:1'b1, vs:1'b1, fe:1'b0, se:1'b1};

        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m_div[i] = 0; m_h[i] = 0; m_v[i] = 0; m_fc[i] = 0;
        end

        // Reset state with the enable low
        step(1'b1, 1'b0);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("rst_active",   64'(d0_act),   64'd1);
        chk("rst_blanking", 64'(d0_blank), 64'd0);
        chk("rst_xy",       64'(d0_xy),    64'd0);
        chk("rst_hs",       64'(d0_hs),    64'd1);
        chk("rst_vs",       64'(d0_vs),    64'd1);
        chk("rst_stb",      64'(d0_stb),   64'd0);
        chk("rst_hs_pol1",  64'(d1_hs),    64'd0);
        step(1'b1, 1'b0);

        // First screen: pixel (h,v) is strobed at clock (v*14+h)*2+1
        phase1 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            run_to((tbl[i].v * 14 + tbl[i].h) * 2 + 1);
            chk("tbl_h",        64'(d0_hc),    64'(tbl[i].h));
            chk("tbl_v",        64'(d0_vc),    64'(tbl[i].v));
            chk("tbl_stb",      64'(d0_stb),   64'd1);
            chk("tbl_xy",       64'(d0_xy),    64'(tbl[i].xy));
            chk("tbl_active",   64'(d0_act),   64'(tbl[i].act));
            chk("tbl_blanking", 64'(d0_blank), 64'(!tbl[i].act));
            chk("tbl_hs",       64'(d0_hs),    64'(tbl[i].hs));
            chk("tbl_vs",       64'(d0_vs),    64'(tbl[i].vs));
            chk("tbl_frameend", 64'(d0_fe),    64'(tbl[i].fe));
            chk("tbl_screenend",64'(d0_se),    64'(tbl[i].se));
        end
        run_to(224);
        chk("frame_cnt_1", 64'(d0_fc), 64'd1);
        run_to(448);
        chk("frame_cnt_2", 64'(d0_fc), 64'd2);
        phase1 = 1'b0;

        // Enable dropped for 10 clocks at h=5 of the third screen
        run_to(458);
        chk("pause_h_before", 64'(d0_hc), 64'd5);
        repeat (10) step(1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b0;
        #1;
        chk("pause_h_held",  64'(d0_hc),  64'd5);
        chk("pause_v_held",  64'(d0_vc),  64'd0);
        chk("pause_xy_held", 64'(d0_xy),  64'd2);
        chk("pause_no_stb",  64'(d0_stb), 64'd0);
        run_to(671);
        chk("slip_no_early_end", 64'(d0_se), 64'd0);
        run_to(681);
        chk("slip_screenend", 64'(d0_se), 64'd1);

        // Reset mid-frame at h=9, v=6 with the enable high
        run_to(868);
        chk("pre_rst_h",  64'(d0_hc), 64'd9);
        chk("pre_rst_v",  64'(d0_vc), 64'd6);
        chk("pre_rst_vs", 64'(d0_vs), 64'd0);
        step(1'b1, 1'b1);
        rst = 1'b0;
        en  = 1'b1;
        #1;
        chk("post_rst_h",  64'(d0_hc), 64'd0);
        chk("post_rst_v",  64'(d0_vc), 64'd0);
        chk("post_rst_xy", 64'(d0_xy), 64'd0);
        chk("post_rst_fc", 64'(d0_fc), 64'd0);
        chk("post_rst_hs", 64'(d0_hs), 64'd1);
        chk("post_rst_vs", 64'(d0_vs), 64'd1);
        repeat (240) step(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
